// File: rtl/sdr_stream_pkg.sv
// Shared types and helpers for the TX sample-stream blocks in front of ad9363_stream.
package sdr_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } t_arb_state;

   localparam int SAMPLE_W = 12;

   // Index width for a requester count; a single requester still gets one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tx_burst_arbiter_rr_select.sv
// Combinational round-robin pick: first set request searching upward from last+1, wrapping.
module rr_select
   import sdr_stream_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IW      = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last,
   output logic               found,
   output logic [IW-1:0]      idx
);

   logic [IW-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest hit is assigned last and wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = IW'((int'(last) + i) % NUM_REQ);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/tx_burst_arbiter.sv
// Burst-granular round-robin arbiter sharing one TX sample stream into ad9363_stream.
// Optional macro TX_IDLE_FILL_EN: emit valid zero samples in ST_IDLE/ST_GAP while enabled.
module tx_burst_arbiter
   import sdr_stream_pkg::*;
#(
   parameter  int NUM_REQ    = 2,
   parameter  int DATA_W     = SAMPLE_W,
   parameter  int MAX_BURST  = 1024,
   parameter  int GAP_CYCLES = 4,
   localparam int IW         = idx_width(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_q,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data_i,
   output logic [DATA_W-1:0]         out_data_q,
   input  logic                      out_ready,
   output logic                      grant_valid,
   output logic [IW-1:0]             grant_idx,
   output logic                      burst_trunc,
   output t_arb_state                arb_state
);

   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_CAP = CW'(MAX_BURST - 1);
   localparam logic [GW-1:0] GAP_END = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   t_arb_state    state, state_n;
   logic [IW-1:0] grant_idx_n;
   logic [IW-1:0] last_owner, last_owner_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [GW-1:0] gap_cnt, gap_cnt_n;
   logic          trunc_n;

   logic          found;
   logic [IW-1:0] winner;
   logic          sel_valid;
   logic          sel_last;
   logic          xfer;

   rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
      .req   (req_valid),
      .last  (last_owner),
      .found (found),
      .idx   (winner)
   );

   assign sel_valid = req_valid[grant_idx];
   assign sel_last  = req_last[grant_idx];

   // last_owner starts at the top index so requester 0 is searched first after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         grant_idx   <= '0;
         last_owner  <= IW'(NUM_REQ - 1);
         cnt         <= '0;
         gap_cnt     <= '0;
         burst_trunc <= 1'b0;
      end else begin
         state       <= state_n;
         grant_idx   <= grant_idx_n;
         last_owner  <= last_owner_n;
         cnt         <= cnt_n;
         gap_cnt     <= gap_cnt_n;
         burst_trunc <= trunc_n;
      end
   end

   always_comb begin
      state_n      = state;
      grant_idx_n  = grant_idx;
      last_owner_n = last_owner;
      cnt_n        = cnt;
      gap_cnt_n    = gap_cnt;
      trunc_n      = 1'b0;
      xfer         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable && found) begin
               state_n      = ST_GRANT;
               grant_idx_n  = winner;
               last_owner_n = winner;
               cnt_n        = '0;
            end
         end
         ST_GRANT: begin
            xfer = sel_valid && out_ready;
            if (xfer) begin
               if (sel_last || (cnt == CNT_CAP)) begin
                  // A cap hit that coincides with last is a normal end, not a truncation.
                  trunc_n   = !sel_last;
                  cnt_n     = '0;
                  gap_cnt_n = '0;
                  state_n   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt == GAP_END) begin
               state_n   = ST_IDLE;
               gap_cnt_n = '0;
            end else begin
               gap_cnt_n = gap_cnt + 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = '0;
      out_valid  = 1'b0;
      out_data_i = '0;
      out_data_q = '0;
      if (state == ST_GRANT) begin
         req_ready[grant_idx] = out_ready;
         out_valid            = sel_valid;
         out_data_i           = req_data_i[int'(grant_idx)*DATA_W +: DATA_W];
         out_data_q           = req_data_q[int'(grant_idx)*DATA_W +: DATA_W];
      end else begin
`ifdef TX_IDLE_FILL_EN
         out_valid = enable;
`endif
      end
   end

   assign grant_valid = (state == ST_GRANT);
   assign arb_state   = state;

endmodule

// File: tb/tb_tx_burst_arbiter.sv
// Directed bench for tx_burst_arbiter: vector table plus multi-cycle stream sequences.
module tb_tx_burst_arbiter;
   import sdr_stream_pkg::*;

   localparam int NR  = 3;
   localparam int DW  = 12;
   localparam int MB  = 8;
   localparam int GAP = 4;
`ifdef TX_IDLE_FILL_EN
   localparam bit FILL = 1'b1;
`else
   localparam bit FILL = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data_i;
   logic [NR*DW-1:0]  req_data_q;
   logic [NR-1:0]     req_last;
   logic [NR-1:0]     req_ready;
   logic              out_valid;
   logic [DW-1:0]     out_data_i;
   logic [DW-1:0]     out_data_q;
   logic              out_ready;
   logic              grant_valid;
   logic [1:0]        grant_idx;
   logic              burst_trunc;
   t_arb_state        arb_state;

   tx_burst_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB), .GAP_CYCLES(GAP)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .req_valid   (req_valid),
      .req_data_i  (req_data_i),
      .req_data_q  (req_data_q),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .out_valid   (out_valid),
      .out_data_i  (out_data_i),
      .out_data_q  (out_data_q),
      .out_ready   (out_ready),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx),
      .burst_trunc (burst_trunc),
      .arb_state   (arb_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_data(input int k, input logic [DW-1:0] v);
      req_data_i[k*DW +: DW] = v;
      req_data_q[k*DW +: DW] = v ^ 12'h0F0;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      enable     = 1'b0;
      req_valid  = '0;
      req_last   = '0;
      req_data_i = '0;
      req_data_q = '0;
      out_ready  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          en;
      logic [2:0]    vld;
      logic [2:0]    last;
      logic          rdy;
      logic [11:0]   di;
      logic          ov;
      logic [11:0]   odi;
      logic          gv;
      logic [1:0]    gi;
      logic [2:0]    rr;
      logic          tr;
      logic [1:0]    st;
   } vec_t;

   function automatic vec_t mk(input logic en, input logic [2:0] vld, input logic [2:0] last,
                               input logic rdy, input logic [11:0] di, input logic ov,
                               input logic [11:0] odi, input logic gv, input logic [1:0] gi,
                               input logic [2:0] rr, input logic tr, input logic [1:0] st);
      vec_t v;
      v.en = en; v.vld = vld; v.last = last; v.rdy = rdy; v.di = di;
      v.ov = ov; v.odi = odi; v.gv = gv; v.gi = gi; v.rr = rr; v.tr = tr; v.st = st;
      return v;
   endfunction

   localparam int NV = 14;
   vec_t tv [NV];

   // ---------------- stream model ----------------
   int            s_burst [NR];
   int            s_total [NR];
   int            s_sent  [NR];
   bit            rdy_toggle;
   int            n_trunc;
   logic [23:0]   exp_q [$];
   logic [1:0]    exp_g [$];

   task automatic clear_model();
      for (int k = 0; k < NR; k++) begin
         s_burst[k] = 0;
         s_total[k] = 0;
         s_sent[k]  = 0;
      end
      rdy_toggle = 1'b0;
      n_trunc    = 0;
      exp_q.delete();
      exp_g.delete();
   endtask

   task automatic run_streams(input int max_cycles);
      int         cyc;
      bit         prev_gv;
      bit         seen;
      int         low_run;
      logic [1:0] cur_g;
      logic [NR-1:0] fire;
      logic [23:0]   e;
      cyc = 0; prev_gv = 1'b0; seen = 1'b0; low_run = 0; cur_g = '0;
      while (cyc < max_cycles && (exp_q.size() > 0 || exp_g.size() > 0)) begin
         @(negedge clk);
         enable = 1'b1;
         for (int k = 0; k < NR; k++) begin
            req_valid[k] = (s_sent[k] < s_total[k]);
            req_last[k]  = req_valid[k] && (s_burst[k] != 0) &&
                           ((s_sent[k] % s_burst[k]) == s_burst[k] - 1);
            set_data(k, 12'(k*256 + s_sent[k]));
         end
         out_ready = rdy_toggle ? ~cyc[0] : 1'b1;
         #1;
         if (grant_valid && !prev_gv) begin
            if (exp_g.size() == 0) begin
               check("extra_grant", 32'(grant_idx), 32'hFFFF_FFFF);
            end else begin
               cur_g = exp_g.pop_front();
               check("grant_order", 32'(grant_idx), 32'(cur_g));
            end
            if (seen) check("gap_len", 32'(low_run), 32'(GAP + 1));
            seen = 1'b1;
         end
         low_run = grant_valid ? 0 : low_run + 1;
         prev_gv = grant_valid;
         if (burst_trunc) n_trunc++;
         if (grant_valid) begin
            check("ready_mirror", 32'(req_ready), out_ready ? (32'd1 << cur_g) : 32'd0);
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("extra_sample", {8'h0, out_data_i, out_data_q}, 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  check("sample", {8'h0, out_data_i, out_data_q}, {8'h0, e});
               end
            end
         end else begin
            check("idle_valid", 32'(out_valid), 32'(FILL));
            check("idle_data", {8'h0, out_data_i, out_data_q}, 32'd0);
         end
         for (int k = 0; k < NR; k++) fire[k] = req_valid[k] && req_ready[k];
         @(posedge clk);
         for (int k = 0; k < NR; k++) s_sent[k] += int'(fire[k]);
         cyc++;
      end
      check("stream_done", 32'(exp_q.size() + exp_g.size()), 32'd0);
   endtask

   function automatic logic [23:0] smp(input int k, input int n);
      logic [11:0] v;
      v = 12'(k*256 + n);
      return {v, v ^ 12'h0F0};
   endfunction

   initial begin
      tv[0]  = mk(1, 3'b001, 3'b000, 1, 12'd1, FILL, 12'h000, 0, 2'd0, 3'b000, 0, 2'd0);
      tv[1]  = mk(1, 3'b001, 3'b000, 1, 12'd1, 1,    12'h001, 1, 2'd0, 3'b001, 0, 2'd1);
      tv[2]  = mk(1, 3'b001, 3'b000, 1, 12'd2, 1,    12'h002, 1, 2'd0, 3'b001, 0, 2'd1);
      tv[3]  = mk(1, 3'b001, 3'b001, 1, 12'd3, 1,    12'h003, 1, 2'd0, 3'b001, 0, 2'd1);
      tv[4]  = mk(1, 3'b000, 3'b000, 1, 12'd4, FILL, 12'h000, 0, 2'd0, 3'b000, 0, 2'd2);
      tv[5]  = mk(1, 3'b000, 3'b000, 1, 12'd4, FILL, 12'h000, 0, 2'd0, 3'b000, 0, 2'd2);
      tv[6]  = mk(1, 3'b000, 3'b000, 1, 12'd4, FILL, 12'h000, 0, 2'd0, 3'b000, 0, 2'd2);
      tv[7]  = mk(1, 3'b000, 3'b000, 1, 12'd4, FILL, 12'h000, 0, 2'd0, 3'b000, 0, 2'd2);
      tv[8]  = mk(1, 3'b000, 3'b000, 1, 12'd4, FILL, 12'h000, 0, 2'd0, 3'b000, 0, 2'd0);
      tv[9]  = mk(1, 3'b110, 3'b000, 1, 12'd5, FILL, 12'h000, 0, 2'd0, 3'b000, 0, 2'd0);
      tv[10] = mk(0, 3'b010, 3'b000, 1, 12'd6, 1,    12'h106, 1, 2'd1, 3'b010, 0, 2'd1);
      tv[11] = mk(0, 3'b000, 3'b000, 1, 12'd7, 0,    12'h107, 1, 2'd1, 3'b010, 0, 2'd1);
      tv[12] = mk(0, 3'b010, 3'b010, 1, 12'd8, 1,    12'h108, 1, 2'd1, 3'b010, 0, 2'd1);
      tv[13] = mk(0, 3'b000, 3'b000, 1, 12'd9, 0,    12'h000, 0, 2'd1, 3'b000, 0, 2'd2);

      // Reset state.
      do_reset();
      #1;
      check("rst_grant_valid", 32'(grant_valid), 32'd0);
      check("rst_grant_idx",   32'(grant_idx),   32'd0);
      check("rst_trunc",       32'(burst_trunc), 32'd0);
      check("rst_req_ready",   32'(req_ready),   32'd0);
      check("rst_out_valid",   32'(out_valid),   32'd0);
      check("rst_state",       32'(arb_state),   32'(ST_IDLE));

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         enable    = tv[i].en;
         req_valid = tv[i].vld;
         req_last  = tv[i].last;
         out_ready = tv[i].rdy;
         for (int k = 0; k < NR; k++) set_data(k, tv[i].di + 12'(k*256));
         #1;
         check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tv[i].ov));
         check($sformatf("v%0d_out_i", i), 32'(out_data_i), 32'(tv[i].odi));
         check($sformatf("v%0d_out_q", i), 32'(out_data_q),
               tv[i].gv ? 32'(tv[i].odi ^ 12'h0F0) : 32'd0);
         check($sformatf("v%0d_grant_valid", i), 32'(grant_valid), 32'(tv[i].gv));
         check($sformatf("v%0d_grant_idx", i), 32'(grant_idx), 32'(tv[i].gi));
         check($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(tv[i].rr));
         check($sformatf("v%0d_trunc", i), 32'(burst_trunc), 32'(tv[i].tr));
         check($sformatf("v%0d_state", i), 32'(arb_state), 32'(tv[i].st));
      end

      // Two competing requesters with 2-sample bursts alternate 0,1,0,1.
      do_reset();
      clear_model();
      s_burst[0] = 2; s_total[0] = 4;
      s_burst[1] = 2; s_total[1] = 4;
      exp_g.push_back(2'd0); exp_g.push_back(2'd1); exp_g.push_back(2'd0); exp_g.push_back(2'd1);
      for (int b = 0; b < 4; b++)
         for (int n = 0; n < 2; n++) exp_q.push_back(smp(b % 2, (b / 2) * 2 + n));
      run_streams(200);

      // Requester 1 streams 20 samples without last: forced releases at the cap.
      do_reset();
      clear_model();
      s_burst[1] = 0; s_total[1] = 20;
      exp_g.push_back(2'd1); exp_g.push_back(2'd1); exp_g.push_back(2'd1);
      for (int n = 0; n < 20; n++) exp_q.push_back(smp(1, n));
      run_streams(200);
      check("trunc_pulses", 32'(n_trunc), 32'd2);
      #1;
      check("hold_without_valid", 32'(grant_valid), 32'd1);

      // Back-pressure toggling every cycle mid-burst.
      do_reset();
      clear_model();
      s_burst[0] = 4; s_total[0] = 8;
      rdy_toggle = 1'b1;
      exp_g.push_back(2'd0); exp_g.push_back(2'd0);
      for (int n = 0; n < 8; n++) exp_q.push_back(smp(0, n));
      run_streams(200);
      check("no_trunc_with_last", 32'(n_trunc), 32'd0);

      // Reset during the second sample, then a 3-way tie goes to requester 0.
      do_reset();
      enable = 1'b1; req_valid = 3'b001; req_last = '0; out_ready = 1'b1;
      set_data(0, 12'd1);
      @(posedge clk);
      @(negedge clk); #1;
      check("d_grant_up", 32'(grant_valid), 32'd1);
      @(posedge clk);
      @(negedge clk);
      set_data(0, 12'd2);
      #1;
      check("d_second_sample", 32'(out_data_i), 32'd2);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 3'b111;
      #1;
      check("d_rst_grant_valid", 32'(grant_valid), 32'd0);
      check("d_rst_req_ready",   32'(req_ready),   32'd0);
      check("d_rst_state",       32'(arb_state),   32'(ST_IDLE));
      check("d_rst_grant_idx",   32'(grant_idx),   32'd0);
      check("d_rst_trunc",       32'(burst_trunc), 32'd0);
      @(posedge clk);
      @(negedge clk); #1;
      check("d_tie_grant", 32'(grant_valid), 32'd1);
      check("d_tie_idx",   32'(grant_idx),   32'd0);

      // enable=0 blocks new grants; raising it grants one cycle later.
      do_reset();
      enable = 1'b0; req_valid = 3'b110; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check("e_no_grant", 32'(grant_valid), 32'd0);
      end
      enable = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
      check("e_grant", 32'(grant_valid), 32'd1);
      check("e_grant_idx", 32'(grant_idx), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
